// File: rtl/uart_tx.sv
// uart_tx -- byte-wide UART transmitter, 8N1 framing, for the host serial link.
//
// A one-byte holding register sits in front of the shift register, so a new
// byte can be written while the previous frame is still on the line. Frames
// then follow each other with no idle gap.
//
// Optional feature macro: UART_TX_PARITY_EN
//    defined   : an even-parity bit is sent between data bit 7 and the stop bit
//                (frame = 11 bit periods).
//    undefined : no parity state or logic (frame = 10 bit periods).
//
// Parameters:
//    I_CLOCK_FREQ  i_clk frequency in Hz
//    BAUD_RATE     line rate in bits/s; BIT_CLKS = I_CLOCK_FREQ / BAUD_RATE (>= 2)
//
// Ports:
//    i_clk    sole clock
//    i_reset  synchronous, active-high reset
//    i_wr     write strobe, accepted only while o_ready = 1
//    i_data   byte to send, sampled on the accepting edge
//    o_ready  holding register empty
//    o_tx     serial line, idle high, driven from a flop
//    o_busy   holding register full or a frame on the line
//
// Shifter states:
//    state  | meaning
//    IDLE   | line idle high, waiting for a held byte
//    START  | start bit (low)
//    DATA   | data bits 0..7, LSB first
//    PARITY | even-parity bit (only with UART_TX_PARITY_EN)
//    STOP   | stop bit (high); chains straight into START if a byte is held

module uart_tx #(
   parameter int I_CLOCK_FREQ = 50_000000,
   parameter int BAUD_RATE    = 115200
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_wr,
   input  logic [7:0] i_data,
   output logic       o_ready,
   output logic       o_tx,
   output logic       o_busy
);

   localparam int BIT_CLKS = I_CLOCK_FREQ / BAUD_RATE;
   localparam int CW       = (BIT_CLKS > 2) ? $clog2(BIT_CLKS) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(BIT_CLKS - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] bit_cnt, bit_cnt_n;
   logic [2:0]    bit_idx, bit_idx_n;
   logic [2:0]    idx_inc;
   logic [7:0]    shift_data;
   logic [7:0]    hold_data;
   logic          hold_valid;
   logic          tx, tx_n;
   logic          load;
   logic          bit_end;

   assign bit_end = (bit_cnt == CNT_MAX);
   assign idx_inc = bit_idx + 3'd1;

   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt + 1'b1;
      bit_idx_n = bit_idx;
      tx_n      = tx;
      load      = 1'b0;
      case (state)
         IDLE: begin
            bit_cnt_n = '0;
            bit_idx_n = 3'd0;
            tx_n      = 1'b1;
            if (hold_valid) begin
               state_n = START;
               load    = 1'b1;
               tx_n    = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               state_n   = DATA;
               bit_cnt_n = '0;
               bit_idx_n = 3'd0;
               tx_n      = shift_data[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               bit_cnt_n = '0;
               if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_n = PARITY;
                  tx_n    = ^shift_data;
`else
                  state_n = STOP;
                  tx_n    = 1'b1;
`endif
               end else begin
                  bit_idx_n = idx_inc;
                  tx_n      = shift_data[idx_inc];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               state_n   = STOP;
               bit_cnt_n = '0;
               tx_n      = 1'b1;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               bit_cnt_n = '0;
               bit_idx_n = 3'd0;
               if (hold_valid) begin
                  state_n = START;
                  load    = 1'b1;
                  tx_n    = 1'b0;
               end else begin
                  state_n = IDLE;
                  tx_n    = 1'b1;
               end
            end
         end
         default: begin
            state_n   = IDLE;
            bit_cnt_n = '0;
            bit_idx_n = 3'd0;
            tx_n      = 1'b1;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         bit_idx    <= 3'd0;
         tx         <= 1'b1;
         shift_data <= 8'h00;
         hold_data  <= 8'h00;
         hold_valid <= 1'b0;
      end else begin
         state   <= state_n;
         bit_cnt <= bit_cnt_n;
         bit_idx <= bit_idx_n;
         tx      <= tx_n;
         if (load)
            shift_data <= hold_data;
         // load needs hold_valid = 1, i.e. o_ready = 0, so it never meets an accepted write
         if (load)
            hold_valid <= 1'b0;
         else if (i_wr && !hold_valid) begin
            hold_valid <= 1'b1;
            hold_data  <= i_data;
         end
      end
   end

   assign o_ready = !hold_valid;
   assign o_tx    = tx;
   assign o_busy  = hold_valid || (state != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- directed bench for uart_tx at BIT_CLKS = 8.
// Outputs are sampled on the falling edge; inputs change on the falling edge.

module tb_uart_tx;

   localparam int BC = 8;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       wr;
   logic [7:0] data;
   logic       ready;
   logic       tx;
   logic       busy;

   int vectors     = 0;
   int miscompares = 0;

   uart_tx #(
      .I_CLOCK_FREQ (1_000_000),
      .BAUD_RATE    (125_000)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .i_wr    (wr),
      .i_data  (data),
      .o_ready (ready),
      .o_tx    (tx),
      .o_busy  (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called on the falling edge of the first start-bit cycle; returns on the
   // falling edge of the first cycle after the stop bit.
   task automatic check_frame(input logic [7:0] b, input logic par, input string tag);
      logic [10:0] f;
`ifdef UART_TX_PARITY_EN
      f = {1'b1, par, b, 1'b0};
`else
      f = {2'b11, b, 1'b0};
`endif
      for (int k = 0; k < NB; k++) begin
         for (int c = 0; c < BC; c++) begin
            check($sformatf("%s p%0d bit%0d cyc%0d", tag, par, k, c), {31'd0, tx}, {31'd0, f[k]});
            @(negedge clk);
         end
      end
   endtask

   // Drives a one-cycle write; returns on the falling edge after the accepting edge.
   task automatic write_byte(input logic [7:0] b);
      wr   = 1'b1;
      data = b;
      @(negedge clk);
      wr   = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, " tx"},    {31'd0, tx},    32'd1);
      check({tag, " ready"}, {31'd0, ready}, 32'd1);
      check({tag, " busy"},  {31'd0, busy},  32'd0);
   endtask

   // Write b from idle, check the start latency, then the whole frame.
   task automatic single(input logic [7:0] b, input logic par, input string tag);
      write_byte(b);
      check({tag, " accept ready"}, {31'd0, ready}, 32'd0);
      check({tag, " accept busy"},  {31'd0, busy},  32'd1);
      check({tag, " accept tx"},    {31'd0, tx},    32'd1);
      @(negedge clk);
      check({tag, " start ready"},  {31'd0, ready}, 32'd1);
      check_frame(b, par, tag);
      check_idle({tag, " after"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst  = 1'b1;
      wr   = 1'b0;
      data = 8'h00;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_idle($sformatf("reset cyc%0d", i));
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_idle($sformatf("post reset cyc%0d", i));
      end

      // single byte
      single(8'h55, 1'b0, "b55");
      repeat (3) @(negedge clk);

      // back-to-back: second write the cycle o_ready rises
      write_byte(8'hA5);
      @(negedge clk);
      check("b2b ready", {31'd0, ready}, 32'd1);
      fork
         check_frame(8'hA5, 1'b0, "b2b A5");
         begin
            write_byte(8'h3C);
            check("b2b held ready", {31'd0, ready}, 32'd0);
         end
      join
      check_frame(8'h3C, 1'b0, "b2b 3C");
      check_idle("b2b after");
      repeat (3) @(negedge clk);

      // overflow: 0x33 written while full must be dropped
      write_byte(8'h11);
      @(negedge clk);
      fork
         check_frame(8'h11, 1'b0, "ovf 11");
         begin
            write_byte(8'h22);
            wr   = 1'b1;
            data = 8'h33;
            repeat (4) @(negedge clk);
            wr   = 1'b0;
            check("ovf still held", {31'd0, ready}, 32'd0);
         end
      join
      check_frame(8'h22, 1'b0, "ovf 22");
      for (int i = 0; i < 3 * NB * BC; i++) begin
         check($sformatf("ovf quiet cyc%0d", i), {30'd0, tx, busy}, 32'd2);
         @(negedge clk);
      end

      // reset during data bit 3 of 0xF0 with 0x0F held
      write_byte(8'hF0);
      @(negedge clk);
      write_byte(8'h0F);
      repeat (BC + 3 * BC + 2 - 1) @(negedge clk);
      check("rst mid bit3", {31'd0, tx}, 32'd0);
      check("rst mid busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check_idle("rst mid next");
      rst = 1'b0;
      for (int i = 0; i < 2 * NB * BC; i++) begin
         check($sformatf("rst quiet cyc%0d", i), {29'd0, tx, ready, busy}, 32'd6);
         @(negedge clk);
      end

      // parity patterns (parity bit only on the line with the macro)
      single(8'h07, 1'b1, "p07");
      single(8'h03, 1'b0, "p03");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
